// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_checker_pkg;

    // Check sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Word addresses inside the system-ID slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Width of the per-read waitrequest stall counter
    localparam int CNT_W = 16;

endpackage

// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp from the sysid slave and reports
// pass / fail / timeout to boot and reset-release logic.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // Abort when this many stalled cycles have already been counted and the
    // slave is still stalling, i.e. after TIMEOUT_CYCLES stalled cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             auto_pending_r;
    logic [31:0]      id_s;
    logic [31:0]      ts_s;
    logic             pass_s;
    logic             timeout_s;
    logic             rd_s;
    logic             addr_s;
    logic             busy_s;
    logic             done_s;

    // Next-state, counter, capture and status computation
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        id_s      = id_value;
        ts_s      = ts_value;
        pass_s    = pass;
        timeout_s = timeout;
        case (state_r)
            ST_IDLE: begin
                if (start || auto_pending_r) begin
                    state_s   = ST_RD_ID;
                    cnt_s     = {CNT_W{1'b0}};
                    pass_s    = 1'b0;
                    timeout_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_ID: begin
                if (!avm_waitrequest) begin
                    id_s    = avm_readdata;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_RD_TS;
                end else if (cnt_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    pass_s    = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_s    = avm_readdata;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_EVAL;
                end else if (cnt_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    pass_s    = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_EVAL: begin
                pass_s  = (id_value == EXPECTED_ID) &&
                          (!CHECK_TIMESTAMP || (ts_value == EXPECTED_TIMESTAMP));
                state_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_s   = ST_RD_ID;
                    cnt_s     = {CNT_W{1'b0}};
                    pass_s    = 1'b0;
                    timeout_s = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Bus and status outputs are decoded from the next state so they register
    // alongside it and stay stable for as long as a read is stalled.
    always_comb begin
        rd_s   = (state_s == ST_RD_ID) || (state_s == ST_RD_TS);
        addr_s = (state_s == ST_RD_TS) ? ADDR_TS : ADDR_ID;
        busy_s = rd_s || (state_s == ST_EVAL);
        done_s = (state_s == ST_DONE);
    end

    // State, counter and registered output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            auto_pending_r <= AUTO_START;
            avm_read       <= 1'b0;
            avm_address    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            id_value       <= 32'h0000_0000;
            ts_value       <= 32'h0000_0000;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            auto_pending_r <= 1'b0;
            avm_read       <= rd_s;
            avm_address    <= addr_s;
            busy           <= busy_s;
            done           <= done_s;
            pass           <= pass_s;
            timeout        <= timeout_s;
            id_value       <= id_s;
            ts_value       <= ts_s;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed self-checking bench for sysid_checker.
// dut0: timestamp checked, long timeout. dut1: timestamp ignored, timeout of 4.
module tb_sysid_checker;

    logic        clk;
    logic        reset;

    logic        start0, start1;
    logic        addr0, addr1;
    logic        read0, read1;
    logic [31:0] rdata0, rdata1;
    logic        wreq0, wreq1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic        pass0, pass1;
    logic        tout0, tout1;
    logic [31:0] idv0, idv1;
    logic [31:0] tsv0, tsv1;

    // slave model controls
    logic [31:0] id0, ts0, id1, ts1;
    int          w0;
    int          st0;
    logic        stuck1;

    int n_checks = 0;
    int n_fail   = 0;

    sysid_checker #(
        .EXPECTED_ID        (32'h0000_CAFE),
        .EXPECTED_TIMESTAMP (32'h5A5A_0001),
        .CHECK_TIMESTAMP    (1'b1),
        .TIMEOUT_CYCLES     (255),
        .AUTO_START         (1'b1)
    ) dut0 (
        .clk             (clk),
        .reset           (reset),
        .start           (start0),
        .avm_address     (addr0),
        .avm_read        (read0),
        .avm_readdata    (rdata0),
        .avm_waitrequest (wreq0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .timeout         (tout0),
        .id_value        (idv0),
        .ts_value        (tsv0)
    );

    sysid_checker #(
        .EXPECTED_ID        (32'h0000_CAFE),
        .EXPECTED_TIMESTAMP (32'h5A5A_0001),
        .CHECK_TIMESTAMP    (1'b0),
        .TIMEOUT_CYCLES     (4),
        .AUTO_START         (1'b1)
    ) dut1 (
        .clk             (clk),
        .reset           (reset),
        .start           (start1),
        .avm_address     (addr1),
        .avm_read        (read1),
        .avm_readdata    (rdata1),
        .avm_waitrequest (wreq1),
        .busy            (busy1),
        .done            (done1),
        .pass            (pass1),
        .timeout         (tout1),
        .id_value        (idv1),
        .ts_value        (tsv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave 0: stalls each read for w0 cycles, then accepts
    assign rdata0 = addr0 ? ts0 : id0;
    assign wreq0  = read0 && (st0 < w0);
    always @(posedge clk) begin
        if (read0 && wreq0) st0 <= st0 + 1;
        else                st0 <= 0;
    end

    // slave 1: zero-wait, or stuck on the timestamp word when stuck1 is set
    assign rdata1 = addr1 ? ts1 : id1;
    assign wreq1  = read1 && stuck1 && addr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        id0    = 32'h0000_CAFE;
        ts0    = 32'h5A5A_0001;
        w0     = 0;
        id1    = 32'h0000_CAFE;
        ts1    = 32'h1234_5678;
        stuck1 = 1'b0;

        // reset values
        step();
        step();
        chk("rst_read", {31'd0, read0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        chk("rst_tout", {31'd0, tout0}, 32'd0);
        chk("rst_idv",  idv0, 32'd0);
        chk("rst_tsv",  tsv0, 32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);

        // auto-start, zero-wait, matching values
        reset = 1'b0;
        step();
        chk("auto_e1_read", {31'd0, read0}, 32'd1);
        chk("auto_e1_addr", {31'd0, addr0}, 32'd0);
        chk("auto_e1_busy", {31'd0, busy0}, 32'd1);
        step();
        chk("auto_e2_read", {31'd0, read0}, 32'd1);
        chk("auto_e2_addr", {31'd0, addr0}, 32'd1);
        step();
        chk("auto_e3_read", {31'd0, read0}, 32'd0);
        chk("auto_e3_busy", {31'd0, busy0}, 32'd1);
        chk("auto_e3_done", {31'd0, done0}, 32'd0);
        step();
        chk("auto_done", {31'd0, done0}, 32'd1);
        chk("auto_pass", {31'd0, pass0}, 32'd1);
        chk("auto_tout", {31'd0, tout0}, 32'd0);
        chk("auto_busy", {31'd0, busy0}, 32'd0);
        chk("auto_idv",  idv0, 32'h0000_CAFE);
        chk("auto_tsv",  tsv0, 32'h5A5A_0001);
        chk("nots_pass1", {31'd0, pass1}, 32'd1);
        chk("nots_tsv1",  tsv1, 32'h1234_5678);

        // ID mismatch after a start pulse
        id0    = 32'h0000_CAFF;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("idbad_done_clr", {31'd0, done0}, 32'd0);
        chk("idbad_pass_clr", {31'd0, pass0}, 32'd0);
        step();
        step();
        step();
        chk("idbad_done", {31'd0, done0}, 32'd1);
        chk("idbad_pass", {31'd0, pass0}, 32'd0);
        chk("idbad_idv",  idv0, 32'h0000_CAFF);

        // three wait cycles per read: bus held stable, done after 10 edges
        id0    = 32'h0000_CAFE;
        w0     = 3;
        start0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) start0 = 1'b0;
            chk($sformatf("wait_read_%0d", i), {31'd0, read0}, {31'd0, (i <= 8)});
            if (i <= 8)
                chk($sformatf("wait_addr_%0d", i), {31'd0, addr0}, {31'd0, (i >= 5)});
            chk($sformatf("wait_done_%0d", i), {31'd0, done0}, {31'd0, (i == 10)});
        end
        chk("wait_pass", {31'd0, pass0}, 32'd1);

        // timeout on dut1: timestamp read stuck for 4 cycles
        ts1    = 32'hDEAD_0000;
        stuck1 = 1'b1;
        start1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) start1 = 1'b0;
            chk($sformatf("to_read_%0d", i), {31'd0, read1}, {31'd0, (i <= 5)});
            if (i >= 2 && i <= 5)
                chk($sformatf("to_addr_%0d", i), {31'd0, addr1}, 32'd1);
        end
        chk("to_timeout", {31'd0, tout1}, 32'd1);
        chk("to_pass",    {31'd0, pass1}, 32'd0);
        chk("to_done",    {31'd0, done1}, 32'd1);
        chk("to_busy",    {31'd0, busy1}, 32'd0);
        chk("to_tsv_kept", tsv1, 32'h1234_5678);
        chk("to_idv",     idv1, 32'h0000_CAFE);

        // rerun on dut1 with a healthy slave; timestamp mismatch is ignored
        stuck1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("rerun_tout_clr", {31'd0, tout1}, 32'd0);
        step();
        step();
        step();
        chk("rerun_done", {31'd0, done1}, 32'd1);
        chk("rerun_pass", {31'd0, pass1}, 32'd1);
        chk("rerun_tsv",  tsv1, 32'hDEAD_0000);

        // start during RD_ID is ignored; reset mid-RD_TS clears immediately
        w0     = 3;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        step();
        chk("mid_e5_read", {31'd0, read0}, 32'd1);
        chk("mid_e5_addr", {31'd0, addr0}, 32'd1);
        chk("mid_e5_busy", {31'd0, busy0}, 32'd1);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_read", {31'd0, read0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_addr", {31'd0, addr0}, 32'd0);
        chk("mid_rst_idv",  idv0, 32'd0);
        w0 = 0;
        step();
        reset = 1'b0;
        step();
        chk("rearm_read", {31'd0, read0}, 32'd1);
        step();
        step();
        step();
        chk("rearm_done", {31'd0, done0}, 32'd1);
        chk("rearm_pass", {31'd0, pass0}, 32'd1);
        chk("rearm_idv",  idv0, 32'h0000_CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
